avnt_ipr2_blkmot: RTL and testbench
===================================

AVNT_IPR2_BLKMOT -- requirements
Module: avnt_ipr2_blkmot

Interface
REQ-001 Parameter IMG_W, 512, active pixels per line (multiple of 2^BLK_LOG2).
REQ-002 Parameter IMG_H, 512, active lines per frame (multiple of 2^BLK_LOG2).
REQ-003 Parameter BLK_LOG2, 3, log2 of square block edge (3 = 8x8).
REQ-004 Parameter PIX_W, 8, pixel bit width.
REQ-005 Derived: NBX=IMG_W>>BLK_LOG2, NBY=IMG_H>>BLK_LOG2, BXW=clog2(NBX), BYW=clog2(NBY), CW=BXW+BYW+1.
REQ-006 clk  in  1  system clock; single clock domain.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 pixel_in  in  PIX_W  raster-order pixel.
REQ-009 frame_valid  in  1  high for the duration of a frame.
REQ-010 data_valid  in  1  pixel_in valid this cycle (qualified by frame_valid).
REQ-011 sensitivity  in  PIX_W  per-block allowed absolute delta.
REQ-012 threshold  in  16  changed-block count limit.
REQ-013 trigger_out  out  1  motion trigger, updated at publish.
REQ-014 stats_valid  out  1  one-cycle pulse when all statistics outputs update.
REQ-015 change_count  out  CW  changed blocks in last frame.
REQ-016 cogx_o / cogy_o  out  BXW / BYW  centre of gravity in block coordinates.
REQ-017 left_o, right_o / top_o, bottom_o  out  BXW / BYW  bounding box of changed blocks.

Function
REQ-018 Pixel counters x,y SHALL clear on frame_valid rising edge and advance raster-wise on frame_valid&&data_valid; pixels beyond IMG_W x IMG_H SHALL be ignored.
REQ-019 Per-block-column partial sums (NBX entries, PIX_W+2*BLK_LOG2 bits, no overflow) SHALL accumulate across the block's rows; full throughput, data_valid may be high every cycle.
REQ-020 On the last pixel of a block, average = sum >> (2*BLK_LOG2) (truncating); changed iff |average - stored previous average| > sensitivity (strictly greater).
REQ-021 Reference memory (NBX*NBY x PIX_W) SHALL be overwritten with each new block average.
REQ-022 First frame after reset: no block flagged changed (ref_valid=0); ref_valid sets after the first complete frame.
REQ-023 For each changed block: count+1, sumx+=bx, sumy+=by, min/max bounding box updated.
REQ-024 FSM states IDLE -> ACTIVE (frame_valid rise) -> SNAP (frame_valid sampled low) -> DIV_X (BXW cycles) -> DIV_Y (BYW cycles) -> PUBLISH (1 cycle) -> IDLE.
REQ-025 SNAP SHALL copy accumulators to divider registers and clear frame accumulators; a new frame may start during DIV_X/DIV_Y without corrupting either frame.
REQ-026 cogx_o=floor(sumx/count), cogy_o=floor(sumy/count) by restoring division; stats_valid SHALL pulse exactly BXW+BYW+2 cycles after frame_valid is first sampled low.
REQ-027 count==0: cog, bbox outputs = 0, trigger_out=0.
REQ-028 trigger_out = (count > threshold) at PUBLISH; held until next PUBLISH.
REQ-029 Truncated frame: only completed blocks evaluated; partial blocks discarded; reference for unvisited blocks retained.

Reset
REQ-030 reset SHALL force all outputs to 0, FSM to IDLE, ref_valid=0, counters/accumulators to 0; memories need not clear; reset mid-frame abandons the frame.

Configuration
REQ-031 Macro IPR2_TRIG_HYST_EN: defined -> trigger_out sets when count > threshold, clears only when count <= threshold>>1, else holds; undefined -> REQ-028 behaviour.

Verification (IMG_W=64, IMG_H=32, BLK_LOG2=3: NBX=8, NBY=4)
REQ-032 Reset, two flat frames of 100 -> both stats_valid pulses with change_count=0, trigger_out=0.
REQ-033 Flat 100 then block (2,1)=130, sensitivity=20, threshold=0 -> count=1, cog=(2,1), left=right=2, top=bottom=1, trigger_out=1.
REQ-034 Block delta exactly 20 with sensitivity=20 -> count=0, trigger_out=0.
REQ-035 Blocks (1,0),(6,3) changed -> count=2, cogx=3, cogy=1, left=1, right=6, top=0, bottom=3.
REQ-036 frame_valid drops after line 15 -> only block rows 0-1 evaluated; stats_valid 7 cycles after drop; new frame_valid rise at cycle 3 still yields correct stats.
REQ-037 threshold=4, counts 5,3,1 -> trigger 1,1,0 with IPR2_TRIG_HYST_EN; 1,0,0 without.

Source files
------------

// File: rtl/avnt_ipr2_blkmot.sv
// Block-average motion detector: compares 2^BLK_LOG2-square block means against the previous
// frame and publishes change count, centre of gravity and bounding box. Optional IPR2_TRIG_HYST_EN.
module avnt_ipr2_blkmot #(
  parameter int IMG_W    = 512,
  parameter int IMG_H    = 512,
  parameter int BLK_LOG2 = 3,
  parameter int PIX_W    = 8,
  localparam int NBX = IMG_W >> BLK_LOG2,
  localparam int NBY = IMG_H >> BLK_LOG2,
  localparam int BXW = $clog2(NBX),
  localparam int BYW = $clog2(NBY),
  localparam int CW  = BXW + BYW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             frame_valid,
  input  logic             data_valid,
  input  logic [PIX_W-1:0] sensitivity,
  input  logic [15:0]      threshold,
  output logic             trigger_out,
  output logic             stats_valid,
  output logic [CW-1:0]    change_count,
  output logic [BXW-1:0]   cogx_o,
  output logic [BYW-1:0]   cogy_o,
  output logic [BXW-1:0]   left_o,
  output logic [BXW-1:0]   right_o,
  output logic [BYW-1:0]   top_o,
  output logic [BYW-1:0]   bottom_o
);

  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H) + 1;
  localparam int SW   = PIX_W + 2 * BLK_LOG2;
  localparam int SXW  = 2 * BXW + BYW;
  localparam int SYW  = 2 * BYW + BXW;
  localparam int NBLK = NBX * NBY;
  localparam int AW   = $clog2(NBLK);
  localparam int DMAX = (BXW > BYW) ? BXW : BYW;
  localparam int SCW  = $clog2(DMAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ACTIVE, S_SNAP, S_DIV_X, S_DIV_Y, S_PUBLISH
  } state_t;

  state_t state, state_nxt;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    logic signed [PIX_W:0] d;
    logic signed [PIX_W:0] m;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    m = (d < 0) ? -d : d;
    return m[PIX_W-1:0];
  endfunction

  logic             fv_d, in_frame, rise_pend, fv_rise;
  logic [XW-1:0]    x_cnt, x_cur;
  logic [YW-1:0]    y_cnt, y_cur;
  logic             pix_ok, blk_first, blk_last;
  logic [BXW-1:0]   bx_cur;
  logic [BYW-1:0]   by_cur;
  logic [SW-1:0]    col_sum [NBX];
  logic [SW-1:0]    sum_nxt;

  assign fv_rise   = frame_valid & ~fv_d;
  assign x_cur     = fv_rise ? '0 : x_cnt;
  assign y_cur     = fv_rise ? '0 : y_cnt;
  // A pixel only counts inside a frame whose rising edge was seen since reset.
  assign pix_ok    = frame_valid && data_valid && (fv_rise || in_frame) && (y_cur < YW'(IMG_H));
  assign bx_cur    = x_cur[XW-1:BLK_LOG2];
  assign by_cur    = y_cur[YW-2:BLK_LOG2];
  assign blk_first = (x_cur[BLK_LOG2-1:0] == '0) && (y_cur[BLK_LOG2-1:0] == '0);
  assign blk_last  = (&x_cur[BLK_LOG2-1:0]) && (&y_cur[BLK_LOG2-1:0]);
  assign sum_nxt   = (blk_first ? '0 : col_sum[bx_cur]) + SW'(pixel_in);

  // stage p0: raster position and per-column block sums
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fv_d     <= 1'b1;
      in_frame <= 1'b0;
      x_cnt    <= '0;
      y_cnt    <= '0;
    end else begin
      fv_d     <= frame_valid;
      in_frame <= frame_valid & (in_frame | fv_rise);
      if (pix_ok) begin
        if (x_cur == XW'(IMG_W - 1)) begin
          x_cnt <= '0;
          y_cnt <= y_cur + YW'(1);
        end else begin
          x_cnt <= x_cur + XW'(1);
          y_cnt <= y_cur;
        end
      end else if (fv_rise) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end
    end
  end

  logic             vld_p1;
  logic [PIX_W-1:0] avg_p1;
  logic [BXW-1:0]   bx_p1;
  logic [BYW-1:0]   by_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      for (int i = 0; i < NBX; i++) col_sum[i] <= '0;
    end else begin
      vld_p1 <= pix_ok && blk_last;
      if (pix_ok) col_sum[bx_cur] <= sum_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_ok && blk_last) begin
      avg_p1 <= sum_nxt[SW-1:2*BLK_LOG2];
      bx_p1  <= bx_cur;
      by_p1  <= by_cur;
    end
  end

  // stage p1: compare against reference, update reference and frame accumulators
  logic [PIX_W-1:0] ref_mem [NBLK];
  logic [AW-1:0]    ref_addr;
  logic [PIX_W-1:0] ref_rd;
  logic             ref_valid, blk_chg, snap;

  assign ref_addr = AW'(by_p1) * AW'(NBX) + AW'(bx_p1);
  assign ref_rd   = ref_mem[ref_addr];
  assign blk_chg  = vld_p1 && ref_valid && (abs_diff(avg_p1, ref_rd) > sensitivity);
  assign snap     = (state == S_SNAP);

  always_ff @(posedge clk) begin
    if (vld_p1) ref_mem[ref_addr] <= avg_p1;
  end

  logic [CW-1:0]  acc_cnt;
  logic [SXW-1:0] acc_sx;
  logic [SYW-1:0] acc_sy;
  logic [BXW-1:0] acc_minx, acc_maxx;
  logic [BYW-1:0] acc_miny, acc_maxy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt  <= '0;
      acc_sx   <= '0;
      acc_sy   <= '0;
      acc_minx <= '0;
      acc_maxx <= '0;
      acc_miny <= '0;
      acc_maxy <= '0;
    end else if (snap) begin
      acc_cnt  <= '0;
      acc_sx   <= '0;
      acc_sy   <= '0;
      acc_minx <= '1;
      acc_maxx <= '0;
      acc_miny <= '1;
      acc_maxy <= '0;
    end else if (blk_chg) begin
      acc_cnt <= acc_cnt + CW'(1);
      acc_sx  <= acc_sx + SXW'(bx_p1);
      acc_sy  <= acc_sy + SYW'(by_p1);
      if (bx_p1 < acc_minx) acc_minx <= bx_p1;
      if (bx_p1 > acc_maxx) acc_maxx <= bx_p1;
      if (by_p1 < acc_miny) acc_miny <= by_p1;
      if (by_p1 > acc_maxy) acc_maxy <= by_p1;
    end
  end

  // stage p2: snapshot and bit-serial restoring division
  logic [CW-1:0]  cnt_s;
  logic [BXW-1:0] minx_s, maxx_s, q_x;
  logic [BYW-1:0] miny_s, maxy_s, q_y;
  logic [SXW-1:0] rem_x, div_x;
  logic [SYW-1:0] rem_y, div_y;
  logic [SCW-1:0] step;
  logic           x_ge, y_ge;

  assign x_ge = (rem_x >= div_x);
  assign y_ge = (rem_y >= div_y);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_valid <= 1'b0;
      step      <= '0;
    end else begin
      if (snap) ref_valid <= 1'b1;
      if (state == S_DIV_X)
        step <= (step == SCW'(BXW - 1)) ? '0 : step + SCW'(1);
      else if (state == S_DIV_Y)
        step <= (step == SCW'(BYW - 1)) ? '0 : step + SCW'(1);
      else
        step <= '0;
    end
  end

  // Quotients are bounded by NBX/NBY, so the divisor starts pre-shifted by width-1.
  always_ff @(posedge clk) begin
    if (snap) begin
      cnt_s  <= acc_cnt;
      minx_s <= acc_minx;
      maxx_s <= acc_maxx;
      miny_s <= acc_miny;
      maxy_s <= acc_maxy;
      rem_x  <= acc_sx;
      div_x  <= SXW'(acc_cnt) << (BXW - 1);
      q_x    <= '0;
      rem_y  <= acc_sy;
      div_y  <= SYW'(acc_cnt) << (BYW - 1);
      q_y    <= '0;
    end else if (state == S_DIV_X) begin
      if (x_ge) rem_x <= rem_x - div_x;
      div_x <= div_x >> 1;
      q_x   <= (q_x << 1) | BXW'(x_ge);
    end else if (state == S_DIV_Y) begin
      if (y_ge) rem_y <= rem_y - div_y;
      div_y <= div_y >> 1;
      q_y   <= (q_y << 1) | BYW'(y_ge);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 rise_pend <= 1'b0;
    else if (state == S_IDLE)  rise_pend <= 1'b0;
    else if (fv_rise)          rise_pend <= 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (fv_rise || rise_pend) state_nxt = S_ACTIVE;
      S_ACTIVE:  if (!frame_valid) state_nxt = S_SNAP;
      S_SNAP:    state_nxt = S_DIV_X;
      S_DIV_X:   if (step == SCW'(BXW - 1)) state_nxt = S_DIV_Y;
      S_DIV_Y:   if (step == SCW'(BYW - 1)) state_nxt = S_PUBLISH;
      S_PUBLISH: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // stage p3: publish
  logic cnt_zero, cnt_gt;
  assign cnt_zero = (cnt_s == '0);
  assign cnt_gt   = 32'(cnt_s) > 32'(threshold);
`ifdef IPR2_TRIG_HYST_EN
  logic cnt_le_half;
  assign cnt_le_half = 32'(cnt_s) <= 32'(threshold >> 1);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stats_valid  <= 1'b0;
      trigger_out  <= 1'b0;
      change_count <= '0;
      cogx_o       <= '0;
      cogy_o       <= '0;
      left_o       <= '0;
      right_o      <= '0;
      top_o        <= '0;
      bottom_o     <= '0;
    end else begin
      stats_valid <= (state == S_PUBLISH);
      if (state == S_PUBLISH) begin
        change_count <= cnt_s;
        cogx_o       <= cnt_zero ? '0 : q_x;
        cogy_o       <= cnt_zero ? '0 : q_y;
        left_o       <= cnt_zero ? '0 : minx_s;
        right_o      <= cnt_zero ? '0 : maxx_s;
        top_o        <= cnt_zero ? '0 : miny_s;
        bottom_o     <= cnt_zero ? '0 : maxy_s;
`ifdef IPR2_TRIG_HYST_EN
        if (cnt_gt)           trigger_out <= 1'b1;
        else if (cnt_le_half) trigger_out <= 1'b0;
`else
        trigger_out <= cnt_gt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_avnt_ipr2_blkmot.sv
// Self-checking bench for avnt_ipr2_blkmot (64x32 image, 8x8 blocks) against a frame-level model.
module tb_avnt_ipr2_blkmot;
  localparam int IMG_W = 64, IMG_H = 32, B = 3, PW = 8;
  localparam int NBX = 8, NBY = 4, LAT = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] pixel_in;
  logic          frame_valid, data_valid;
  logic [PW-1:0] sensitivity;
  logic [15:0]   threshold;
  logic          trigger_out, stats_valid;
  logic [5:0]    change_count;
  logic [2:0]    cogx_o, left_o, right_o;
  logic [1:0]    cogy_o, top_o, bottom_o;

  avnt_ipr2_blkmot #(.IMG_W(IMG_W), .IMG_H(IMG_H), .BLK_LOG2(B), .PIX_W(PW)) dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .frame_valid(frame_valid),
    .data_valid(data_valid), .sensitivity(sensitivity), .threshold(threshold),
    .trigger_out(trigger_out), .stats_valid(stats_valid), .change_count(change_count),
    .cogx_o(cogx_o), .cogy_o(cogy_o), .left_o(left_o), .right_o(right_o),
    .top_o(top_o), .bottom_o(bottom_o));

  always #5 clk = ~clk;

  int img [0:33][0:63];
  int mref [0:3][0:7];
  bit mref_valid;
  bit exp_trig;
  int e_cnt, e_cx, e_cy, e_l, e_r, e_t, e_b;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_flat(input int v);
    for (int y = 0; y < 34; y++) for (int x = 0; x < 64; x++) img[y][x] = v;
  endtask

  task automatic set_blk(input int bx, input int by, input int v);
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) img[by*8+y][bx*8+x] = v;
  endtask

  // Each block is either left untouched or refilled with a new noisy random level.
  task automatic fill_mix();
    for (int by = 0; by < 5; by++)
      for (int bx = 0; bx < NBX; bx++)
        if ($urandom_range(0, 1) == 1) begin
          int base;
          base = $urandom_range(0, 255);
          for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
              int v;
              if (by*8+y > 33) continue;
              v = base + $urandom_range(0, 16) - 8;
              if (v < 0) v = 0;
              if (v > 255) v = 255;
              img[by*8+y][bx*8+x] = v;
            end
        end
  endtask

  task automatic model_frame(input int nlines, input int sens, input int thr);
    int cnt, sx, sy, l, r, t, bt;
    cnt = 0; sx = 0; sy = 0; l = 99; r = -1; t = 99; bt = -1;
    for (int by = 0; by < NBY; by++) begin
      if ((by + 1) * 8 > nlines) continue;
      for (int bx = 0; bx < NBX; bx++) begin
        int sum, avg, d;
        sum = 0;
        for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) sum += img[by*8+y][bx*8+x];
        avg = sum / 64;
        d = avg - mref[by][bx];
        if (d < 0) d = -d;
        if (mref_valid && d > sens) begin
          cnt++; sx += bx; sy += by;
          if (bx < l) l = bx;
          if (bx > r) r = bx;
          if (by < t) t = by;
          if (by > bt) bt = by;
        end
        mref[by][bx] = avg;
      end
    end
    mref_valid = 1'b1;
    e_cnt = cnt;
    if (cnt == 0) begin
      e_cx = 0; e_cy = 0; e_l = 0; e_r = 0; e_t = 0; e_b = 0;
    end else begin
      e_cx = sx / cnt; e_cy = sy / cnt; e_l = l; e_r = r; e_t = t; e_b = bt;
    end
`ifdef IPR2_TRIG_HYST_EN
    if (cnt > thr) exp_trig = 1'b1;
    else if (cnt <= thr / 2) exp_trig = 1'b0;
`else
    exp_trig = (cnt > thr);
`endif
  endtask

  task automatic send_pixels(input int nlines, input bit gaps);
    @(negedge clk);
    frame_valid = 1'b1;
    data_valid  = 1'b0;
    for (int y = 0; y < nlines; y++)
      for (int x = 0; x < IMG_W; x++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          @(negedge clk);
          data_valid = 1'b0;
        end
        @(negedge clk);
        data_valid = 1'b1;
        pixel_in   = 8'(img[y][x]);
      end
  endtask

  task automatic drop_fv();
    @(negedge clk);
    frame_valid = 1'b0;
    data_valid  = 1'b0;
  endtask

  task automatic wait_stats(input string tag);
    int n;
    n = -1;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (stats_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    chk($sformatf("%s.latency", tag), n, LAT);
    chk($sformatf("%s.count", tag), 32'(change_count), e_cnt);
    chk($sformatf("%s.cogx", tag), 32'(cogx_o), e_cx);
    chk($sformatf("%s.cogy", tag), 32'(cogy_o), e_cy);
    chk($sformatf("%s.left", tag), 32'(left_o), e_l);
    chk($sformatf("%s.right", tag), 32'(right_o), e_r);
    chk($sformatf("%s.top", tag), 32'(top_o), e_t);
    chk($sformatf("%s.bottom", tag), 32'(bottom_o), e_b);
    chk($sformatf("%s.trigger", tag), 32'(trigger_out), 32'(exp_trig));
    @(posedge clk);
    #1;
    chk($sformatf("%s.pulse", tag), 32'(stats_valid), 0);
  endtask

  task automatic run_frame(input string tag, input int nlines, input bit gaps);
    send_pixels(nlines, gaps);
    model_frame(nlines, int'(sensitivity), int'(threshold));
    drop_fv();
    wait_stats(tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk($sformatf("%s.stats_valid", tag), 32'(stats_valid), 0);
    chk($sformatf("%s.trigger", tag), 32'(trigger_out), 0);
    chk($sformatf("%s.count", tag), 32'(change_count), 0);
    chk($sformatf("%s.cog", tag), {cogx_o, cogy_o}, 0);
    chk($sformatf("%s.bbox", tag), {left_o, right_o, top_o, bottom_o}, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; frame_valid = 1'b0; data_valid = 1'b0; pixel_in = '0;
    sensitivity = 8'd20; threshold = 16'd0;
    mref_valid = 1'b0; exp_trig = 1'b0;
    for (int y = 0; y < 4; y++) for (int x = 0; x < 8; x++) mref[y][x] = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    fill_flat(100);
    run_frame("flat1", 32, 1'b0);
    run_frame("flat2", 32, 1'b0);

    set_blk(2, 1, 130);
    run_frame("blk21", 32, 1'b0);
    chk("blk21.trig_dir", 32'(trigger_out), 1);

    set_blk(2, 1, 150);
    run_frame("delta20", 32, 1'b0);
    chk("delta20.count_dir", 32'(change_count), 0);

    set_blk(1, 0, 50);
    set_blk(6, 3, 200);
    run_frame("two", 32, 1'b0);
    chk("two.cog_dir", {cogx_o, cogy_o}, {3'd3, 2'd1});

    // Truncated frame followed by a frame that starts while the divider is busy.
    sensitivity = 8'd10;
    threshold   = 16'd3;
    fill_mix();
    send_pixels(16, 1'b1);
    model_frame(16, int'(sensitivity), int'(threshold));
    drop_fv();
    fill_mix();
    fork
      wait_stats("trunc");
      begin
        repeat (2) @(negedge clk);
        send_pixels(32, 1'b0);
      end
    join
    model_frame(32, int'(sensitivity), int'(threshold));
    drop_fv();
    wait_stats("overlap");

    sensitivity = 8'd20;
    threshold   = 16'd4;
    fill_flat(100);
    run_frame("h0", 32, 1'b0);
    for (int bx = 0; bx < 5; bx++) set_blk(bx, 0, 150);
    run_frame("h5", 32, 1'b0);
    chk("h5.count_dir", 32'(change_count), 5);
    chk("h5.trig_dir", 32'(trigger_out), 1);
    for (int bx = 0; bx < 3; bx++) set_blk(bx, 0, 100);
    run_frame("h3", 32, 1'b1);
    chk("h3.count_dir", 32'(change_count), 3);
`ifdef IPR2_TRIG_HYST_EN
    chk("h3.trig_dir", 32'(trigger_out), 1);
`else
    chk("h3.trig_dir", 32'(trigger_out), 0);
`endif
    set_blk(3, 0, 100);
    run_frame("h1", 32, 1'b0);
    chk("h1.count_dir", 32'(change_count), 1);
    chk("h1.trig_dir", 32'(trigger_out), 0);

    for (int k = 0; k < 3; k++) begin
      int nl;
      sensitivity = 8'($urandom_range(0, 40));
      threshold   = 16'($urandom_range(0, 12));
      nl = (k == 0) ? 33 : ((k == 1) ? 24 : 32);
      fill_mix();
      run_frame($sformatf("rand%0d", k), nl, 1'b1);
    end

    // Reset in the middle of a frame abandons it and invalidates the reference.
    fill_mix();
    send_pixels(5, 1'b0);
    @(negedge clk);
    reset = 1'b1; frame_valid = 1'b0; data_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("midrst");
    reset = 1'b0;
    mref_valid = 1'b0;
    exp_trig   = 1'b0;
    sensitivity = 8'd5;
    threshold   = 16'd2;
    fill_mix();
    run_frame("postrst1", 32, 1'b1);
    fill_mix();
    run_frame("postrst2", 32, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
